// File: rtl/scan_display_ctrl.sv
// Multiplexed seven-segment scan controller: one shared active-low segment bus,
// one-hot active-low digit enables, PWM brightness, blanking and zero suppression.
module scan_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int SEL_W      = 3,
  parameter int DIV_W      = 4,
  parameter int DUTY_W     = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic [4*NUM_DIGITS-1:0]   DATA,
  input  logic [NUM_DIGITS-1:0]     DP,
  input  logic [NUM_DIGITS-1:0]     BLANK,
  input  logic                      LZS,
  input  logic [DUTY_W:0]           DUTY,
  output logic [SEL_W-1:0]          SEL,
  output logic [NUM_DIGITS-1:0]     DIG,
  output logic [6:0]                SEG,
  output logic                      DPO,
  output logic                      FRAME
);

  localparam logic [SEL_W-1:0]  LAST_SLOT = SEL_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0]  CNT_MAX   = '1;
  localparam logic [DUTY_W:0]   DUTY_FULL = {1'b1, {DUTY_W{1'b0}}};

  logic [SEL_W-1:0]      r_slot;
  logic [DIV_W-1:0]      r_cnt;

  logic [3:0]            w_nib;
  logic                  w_blank;
  logic                  w_dp;
  logic                  w_supp_cur;
  logic                  w_zero_run;
  logic [NUM_DIGITS-1:0] w_supp;
  logic [DUTY_W-1:0]     w_cnt_hi;
  logic                  w_duty_ok;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_dig;
  logic [6:0]            w_seg;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Leading-zero run is accumulated from the most significant digit downwards.
  always_comb begin
    w_zero_run = 1'b1;
    w_supp     = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run && (DATA[4*i +: 4] == 4'h0);
      w_supp[i]  = LZS && w_zero_run;
    end
  end

  always_comb begin
    w_nib      = 4'h0;
    w_blank    = 1'b0;
    w_dp       = 1'b0;
    w_supp_cur = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_slot == SEL_W'(i)) begin
        w_nib      = DATA[4*i +: 4];
        w_blank    = BLANK[i];
        w_dp       = DP[i];
        w_supp_cur = w_supp[i];
      end
    end
  end

  // cnt==0 is always dark so the previous digit's pattern never ghosts onto the next.
  always_comb begin
    w_cnt_hi  = r_cnt[DIV_W-1 -: DUTY_W];
    w_duty_ok = (DUTY >= DUTY_FULL) || ({1'b0, w_cnt_hi} < DUTY);
    w_lit     = EN && (r_cnt != '0) && !w_blank && !w_supp_cur && w_duty_ok;
    w_seg     = w_lit ? hex_decode(w_nib) : 7'h7F;
    w_dig     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_lit && (r_slot == SEL_W'(i))) w_dig[i] = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_slot <= '0;
      r_cnt  <= '0;
      SEL    <= '0;
      DIG    <= '1;
      SEG    <= 7'h7F;
      DPO    <= 1'b1;
      FRAME  <= 1'b0;
    end else begin
      if (EN) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_MAX) begin
          r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + 1'b1;
        end
      end
      SEL   <= r_slot;
      DIG   <= w_dig;
      SEG   <= w_seg;
      DPO   <= !(w_lit && w_dp);
      // SEL still holds the previous slot here, so this fires as SEL goes last -> 0.
      FRAME <= EN && (r_slot == '0) && (SEL == LAST_SLOT);
    end
  end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Bench for scan_display_ctrl: a cycle model pushes expected outputs into a queue,
// which are popped and compared one cycle later; per-frame lit counts are checked too.
module tb_scan_display_ctrl;

  localparam int N = 6;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic [23:0] DATA;
  logic [5:0]  DP;
  logic [5:0]  BLANK;
  logic        LZS;
  logic [3:0]  DUTY;
  logic [2:0]  SEL;
  logic [5:0]  DIG;
  logic [6:0]  SEG;
  logic        DPO;
  logic        FRAME;

  scan_display_ctrl #(.NUM_DIGITS(6), .SEL_W(3), .DIV_W(4), .DUTY_W(3)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DATA(DATA), .DP(DP), .BLANK(BLANK),
    .LZS(LZS), .DUTY(DUTY), .SEL(SEL), .DIG(DIG), .SEG(SEG), .DPO(DPO), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  logic [17:0] exp_q[$];
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [2:0] m_slot;
  logic [3:0] m_cnt;
  logic [2:0] m_prev_sel;
  logic [2:0] obs_sel;
  int         lit_cnt [N];
  int         dpo_cnt;
  int         frame_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic suppressed(input int d);
    if (!LZS || d == 0) return 1'b0;
    for (int j = d; j < N; j++) if (DATA[4*j +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_slot = 3'd0;
    m_cnt = 4'd0;
    m_prev_sel = 3'd0;
    exp_q.delete();
  endtask

  task automatic clear_stats();
    for (int d = 0; d < N; d++) lit_cnt[d] = 0;
    dpo_cnt = 0;
    frame_cnt = 0;
  endtask

  // One clock: predict the registered outputs from model state, then compare them.
  task automatic step();
    logic       lit;
    logic [5:0] dig;
    logic [6:0] seg;
    logic       dpo;
    logic       frame;
    logic [3:0] nib;
    nib = DATA[4*m_slot +: 4];
    lit = EN && (m_cnt != 4'd0) && !BLANK[m_slot] && !suppressed(int'(m_slot)) &&
          ((DUTY >= 4'd8) || ((m_cnt >> 1) < DUTY));
    dig = 6'h3F;
    if (lit) dig[m_slot] = 1'b0;
    seg = lit ? hex_tab[nib] : 7'h7F;
    dpo = !(lit && DP[m_slot]);
    frame = EN && (m_slot == 3'd0) && (m_prev_sel == 3'(N - 1));
    exp_q.push_back({m_slot, dig, seg, dpo, frame});
    m_prev_sel = m_slot;
    @(posedge CLK);
    if (EN) begin
      if (m_cnt == 4'd15) m_slot = (m_slot == 3'(N - 1)) ? 3'd0 : m_slot + 3'd1;
      m_cnt = m_cnt + 4'd1;
    end
    @(negedge CLK);
    obs_sel = SEL;
    if (exp_q.size() == 0) chk("q_empty", 32'd1, 32'd0);
    else chk("out", {14'd0, SEL, DIG, SEG, DPO, FRAME}, {14'd0, exp_q.pop_front()});
    for (int d = 0; d < N; d++) if (!DIG[d]) lit_cnt[d]++;
    if (!DPO) dpo_cnt++;
    if (FRAME) frame_cnt++;
  endtask

  task automatic run_until(input logic [2:0] slot, input logic [3:0] cnt);
    int guard = 0;
    while (!(m_slot == slot && m_cnt == cnt) && guard < 300) begin
      step();
      guard++;
    end
    if (guard >= 300) chk("align_timeout", 32'd1, 32'd0);
  endtask

  // Measures one whole frame starting at slot 0 / cnt 0.
  task automatic frame_check(input string tag, input logic [5:0] mask, input int exp_lit,
                             input int exp_dpo);
    run_until(3'd0, 4'd0);
    clear_stats();
    repeat (96) step();
    for (int d = 0; d < N; d++)
      chk($sformatf("%s_lit%0d", tag, d), lit_cnt[d], mask[d] ? exp_lit : 0);
    chk({tag, "_frame"}, frame_cnt, 1);
    chk({tag, "_dpo"}, dpo_cnt, exp_dpo);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    RST = 1'b1; EN = 1'b0; DATA = 24'h123456; DP = 6'h00; BLANK = 6'h00;
    LZS = 1'b0; DUTY = 4'd8;
    clear_stats();
    repeat (2) @(negedge CLK);
    chk("por_out", {14'd0, SEL, DIG, SEG, DPO, FRAME}, {14'd0, 3'd0, 6'h3F, 7'h7F, 1'b1, 1'b0});
    model_reset();
    RST = 1'b0;

    // Slot 0 lasts 16 cycles after reset release, then reset again mid-slot 3.
    EN = 1'b1;
    c = 0;
    repeat (17) begin step(); if (obs_sel == 3'd0) c++; end
    chk("t1_sel0_len", c, 16);
    chk("t1_sel_next", obs_sel, 3'd1);
    run_until(3'd3, 4'd7);
    #2 RST = 1'b1;
    #1;
    chk("t1_rst_sel", SEL, 3'd0);
    chk("t1_rst_dig", DIG, 6'h3F);
    chk("t1_rst_seg", SEG, 7'h7F);
    chk("t1_rst_dpo", DPO, 1'b1);
    chk("t1_rst_frame", FRAME, 1'b0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    c = 0;
    repeat (17) begin step(); if (obs_sel == 3'd0) c++; end
    chk("t1_sel0_len2", c, 16);

    frame_check("t2", 6'h3F, 15, 0);

    DUTY = 4'd4;  frame_check("t3_d4", 6'h3F, 7, 0);
    DUTY = 4'd0;  frame_check("t3_d0", 6'h3F, 0, 0);
    DUTY = 4'd15; frame_check("t3_d15", 6'h3F, 15, 0);
    DUTY = 4'd8;

    LZS = 1'b1; DATA = 24'h000070; frame_check("t4_lzs70", 6'b000011, 15, 0);
    DATA = 24'h000000;             frame_check("t4_lzs0", 6'b000001, 15, 0);
    LZS = 1'b0; DATA = 24'h123456;

    // Pause in slot 2 at cnt 9; the slot must resume and finish 7 cycles later.
    run_until(3'd2, 4'd9);
    EN = 1'b0;
    clear_stats();
    repeat (20) step();
    chk("t5_hold_sel", obs_sel, 3'd2);
    chk("t5_hold_frame", frame_cnt, 0);
    chk("t5_hold_lit2", lit_cnt[2], 0);
    EN = 1'b1;
    c = 0;
    repeat (8) begin step(); if (obs_sel == 3'd2) c++; end
    chk("t5_resume_len", c, 7);
    chk("t5_resume_next", obs_sel, 3'd3);

    BLANK = 6'b000100; DP = 6'b010000;
    frame_check("t6", 6'b111011, 15, 15);
    BLANK = 6'h00; DP = 6'h00;

    repeat (400) begin
      if ($urandom_range(0, 7) == 0) begin
        DATA  = 24'($urandom);
        DP    = 6'($urandom);
        BLANK = 6'($urandom_range(0, 3) == 0 ? $urandom : 0);
        LZS   = 1'($urandom_range(0, 1));
        DUTY  = 4'($urandom_range(0, 15));
        EN    = ($urandom_range(0, 5) != 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_display_ctrl.md
Name: scan_display_ctrl

Overview:
Parametrised multiplexed seven-segment scan controller. Time-multiplexes NUM_DIGITS hex digits onto one shared segment bus with one-hot active-low digit enables. Adds per-slot prescaling, PWM brightness, anti-ghost blanking, per-digit blank and decimal point, and leading-zero suppression. Sits between the display-data registers and the board's segment/digit pins.

Parameters:
NUM_DIGITS, 6, number of multiplexed digits (2..8)
SEL_W, 3, width of SEL; 2**SEL_W >= NUM_DIGITS
DIV_W, 4, prescaler width; each digit slot lasts 2**DIV_W clocks
DUTY_W, 3, brightness resolution; DUTY_W <= DIV_W

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-high
EN  in  1  scan run enable
DATA  in  4*NUM_DIGITS  hex nibbles; digit i = DATA[4i+3:4i], digit 0 least significant
DP  in  NUM_DIGITS  decimal point request per digit, active-high
BLANK  in  NUM_DIGITS  force digit dark, active-high
LZS  in  1  leading-zero suppression enable
DUTY  in  DUTY_W+1  brightness, 0..2**DUTY_W; larger values saturate to full
SEL  out  SEL_W  current digit index
DIG  out  NUM_DIGITS  digit enables, active-low, at most one low
SEG  out  7  segments {g,f,e,d,c,b,a}, active-low
DPO  out  1  decimal point segment, active-low
FRAME  out  1  one-cycle pulse at frame wrap

Behaviour:
- Reset, asynchronous, immediate on RST high: slot=0, cnt=0, SEL=0, DIG=all 1, SEG=7'h7F, DPO=1, FRAME=0. Reset mid-scan abandons the slot. Scan restarts at digit 0 on the first edge after RST falls.
- Internal state: slot (0..NUM_DIGITS-1), cnt (DIV_W bits).
- EN=1, each edge: cnt <= cnt+1, wrapping at 2**DIV_W-1. When cnt==2**DIV_W-1 (tick), slot advances; slot NUM_DIGITS-1 wraps to 0. Unused SEL codes are never entered.
- EN=0: slot and cnt hold. Registered outputs give DIG=all 1, SEG=7'h7F, DPO=1, FRAME=0, SEL=slot. Re-enabling resumes the same slot and cnt.
- All outputs are registered from the current slot and cnt, so they lag the internal state by one clock. SEL is the registered slot.
- lit = EN && cnt!=0 && !BLANK[slot] && !suppressed[slot] && (DUTY>=2**DUTY_W || cnt[DIV_W-1 -: DUTY_W] < DUTY).
- cnt==0 is the anti-ghost cycle: the digit is always dark on the first cycle of each slot.
- DIG[slot] = !lit. All other DIG bits are 1.
- SEG = lit ? hexdecode(nibble[slot]) : 7'h7F. DPO = !(lit && DP[slot]).
- Hex decode, active-low: 0=7'h40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Leading-zero suppression, combinational on live DATA: with LZS=1, digit i (i>=1) is suppressed if nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed.
- FRAME=1 for exactly one cycle, registered from the tick where slot wraps NUM_DIGITS-1 -> 0. It coincides with SEL going to 0.
- DATA, DP, BLANK, LZS and DUTY are sampled every cycle with no latching, so changes appear on the next edge.
- Lit cycles per slot: DUTY=0 gives none. DUTY=k < 2**DUTY_W gives k*2**(DIV_W-DUTY_W)-1. Full gives 2**DIV_W-1.

Test Plan:
1. Assert RST during slot 3, mid-cnt, without a clock edge -> SEL=0, DIG=6'b111111, SEG=7'h7F, FRAME=0 immediately. After release, SEL=0 for 16 cycles, then 1.
2. Defaults, EN=1, DUTY=8, DATA=24'h123456, LZS=0 -> SEL steps 0..5, each held 16 cycles. Slot 0 shows DIG=6'b111110 and SEG=7'h02 on 15 of 16 cycles, dark on the first. FRAME pulses once every 96 cycles.
3. DUTY=4 -> DIG low 7 of 16 cycles per slot. DUTY=0 -> DIG never low. DUTY=15 -> same as DUTY=8 (15 cycles).
4. LZS=1, DATA=24'h000070 -> digits 5..2 dark, digit 1 SEG=7'h78, digit 0 SEG=7'h40. DATA=0 -> only digit 0 lit, showing 7'h40.
5. EN dropped in slot 2 at cnt=9 for 20 cycles -> SEL stays 2, DIG=all 1, SEG=7'h7F, no FRAME. On EN=1, slot 2 resumes from cnt 9 and finishes after 7 more cycles.
6. BLANK=6'b000100, DP=6'b010000 -> digit 2 never lit. DPO=0 only during slot 4 lit cycles, 1 elsewhere.
